pkt_rr_arbiter: RTL

- Packet-atomic round-robin arbiter that merges NUM_IN Avalon-ST requesters into one Avalon-ST stream feeding a shared unified FIFO.
- Holds a grant from the first beat of a packet until that packet's eop beat is accepted, so packets from different requesters never interleave in the shared FIFO.
- Honours the FIFO's almost_full at packet boundaries.
- Exports packet and protocol-error counters for the stats path.

---
 rtl/pkt_rr_arbiter.sv | 70 +++++++
 1 files changed

// File: rtl/pkt_rr_arbiter.sv
// pkt_rr_arbiter: packet-atomic round-robin merge of NUM_IN Avalon-ST sources into one stream
module pkt_rr_arbiter #(
  parameter int NUM_IN      = 4,
  parameter int DATA_WIDTH  = 512,
  parameter int EMPTY_WIDTH = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_IN*DATA_WIDTH-1:0]   in_data,
  input  logic [NUM_IN-1:0]              in_valid,
  input  logic [NUM_IN-1:0]              in_sop,
  input  logic [NUM_IN-1:0]              in_eop,
  input  logic [NUM_IN*EMPTY_WIDTH-1:0]  in_empty,
  output logic [NUM_IN-1:0]              in_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           out_valid,
  output logic                           out_sop,
  output logic                           out_eop,
  output logic [EMPTY_WIDTH-1:0]         out_empty,
  input  logic                           out_ready,
  input  logic                           out_almost_full,
  output logic [$clog2(NUM_IN)-1:0]      grant_idx,
  output logic                           locked,
  output logic [31:0]                    pkt_cnt,
  output logic [31:0]                    err_cnt
);
  localparam int GW = $clog2(NUM_IN);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_n;
  logic [GW-1:0] last_grant, winner;
  logic first, beat, grab, proto_err;
  // descending scan so the nearest requester after last_grant wins
  always_comb begin
    winner = '0;
    for (int k = NUM_IN; k >= 1; k--)
      if (in_valid[(int'(last_grant) + k) % NUM_IN]) winner = GW'((int'(last_grant) + k) % NUM_IN);
  end
  always_comb begin
    locked    = state == LOCKED;
    grab      = state == IDLE && |in_valid && !out_almost_full;
    out_valid = locked ? in_valid[grant_idx] : 1'b0;
    out_sop   = locked ? in_sop[grant_idx] : 1'b0;
    out_eop   = locked ? in_eop[grant_idx] : 1'b0;
    out_data  = locked ? in_data[grant_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
    out_empty = locked ? in_empty[grant_idx*EMPTY_WIDTH +: EMPTY_WIDTH] : '0;
    in_ready  = locked ? NUM_IN'(out_ready) << grant_idx : '0;
    beat      = out_valid && out_ready;
    proto_err = beat && (first ? !out_sop : out_sop);
    state_n   = grab ? LOCKED : (beat && out_eop) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant_idx  <= '0;
      last_grant <= GW'(NUM_IN - 1);
      first      <= 1'b0;
      pkt_cnt    <= '0;
      err_cnt    <= '0;
    end else begin
      state   <= state_n;
      pkt_cnt <= pkt_cnt + 32'(beat && out_eop);
      err_cnt <= err_cnt + 32'(proto_err);
      if (grab) begin
        grant_idx  <= winner;
        last_grant <= winner;
        first      <= 1'b1;
      end else if (beat) first <= 1'b0;
    end
  end
endmodule
